// File: rtl/encoder_4x2_rr_pkg.sv
// Shared sizes and FSM encoding for the round-robin 4-to-2 request encoder.
package encoder_4x2_rr_pkg;

    localparam int N_REQ  = 4;
    localparam int ADDR_W = 2;
    localparam int CNT_W  = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/encoder_4x2_rr_if.sv
// Request/present/status bundle between a requester-consumer and the encoder.
interface encoder_4x2_rr_if;
    import encoder_4x2_rr_pkg::*;

    logic              en;
    logic [N_REQ-1:0]  req;
    logic [ADDR_W-1:0] addr;
    logic              valid;
    logic              ready;
    logic [N_REQ-1:0]  pending;
    logic              ovf;
    logic              busy;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  en, req, ready,
        output addr, valid, pending, ovf, busy, count
    );

    modport master (
        output en, req, ready,
        input  addr, valid, pending, ovf, busy, count
    );

endinterface

// File: rtl/encoder_4x2_rr_rr_pick.sv
// Combinational round-robin selector: first set pending bit at or after ptr, wrapping.
module rr_pick
    import encoder_4x2_rr_pkg::*;
(
    input  logic [N_REQ-1:0]  i_pending,
    input  logic [ADDR_W-1:0] i_ptr,
    output logic [ADDR_W-1:0] o_pick,
    output logic              o_any
);

    logic [ADDR_W-1:0] w_idx;

    // Scan from the farthest offset down so the nearest set bit to ptr wins.
    always_comb begin
        o_pick = i_ptr;
        o_any  = |i_pending;
        w_idx  = i_ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = i_ptr + ADDR_W'(k);
            if (i_pending[w_idx]) begin
                o_pick = w_idx;
            end
        end
    end

endmodule

// File: rtl/encoder_4x2_rr.sv
// Latches multi-hot requests and presents them one address at a time, round-robin,
// over a valid/ready handshake with back-to-back throughput.
module encoder_4x2_rr
    import encoder_4x2_rr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    encoder_4x2_rr_if.slave   bus
);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_ptr;
    logic [N_REQ-1:0]  r_pending;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_count;

    logic [ADDR_W-1:0] w_pick;
    logic              w_any;
    logic              w_load;
    logic              w_hs;
    logic [N_REQ-1:0]  w_load_mask;
    logic [N_REQ-1:0]  w_capture;
    logic [N_REQ-1:0]  w_pending_next;
    logic              w_ovf_next;

    // Selection sees only the registered pending set, so fresh captures wait a cycle.
    rr_pick u_rr_pick (
        .i_pending (r_pending),
        .i_ptr     (r_ptr),
        .o_pick    (w_pick),
        .o_any     (w_any)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_hs         = (r_state == PRESENT) && bus.ready;
        if (r_state == IDLE) begin
            if (w_any) begin
                w_state_next = PRESENT;
                w_load       = 1'b1;
            end
        end else begin
            if (bus.ready) begin
                if (w_any) begin
                    w_load = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
        end

        w_load_mask    = w_load ? (N_REQ'(1) << w_pick) : '0;
        w_capture      = bus.en ? bus.req : '0;
        // A capture on a bit being loaded this edge re-arms it rather than flagging overflow.
        w_pending_next = (r_pending & ~w_load_mask) | w_capture;
        w_ovf_next     = |(w_capture & r_pending & ~w_load_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_addr    <= '0;
            r_ptr     <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            r_ovf     <= w_ovf_next;
            if (w_load) begin
                r_addr <= w_pick;
                r_ptr  <= w_pick + 1'b1;
            end
            if (w_hs) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign bus.addr    = r_addr;
    assign bus.valid   = (r_state == PRESENT);
    assign bus.pending = r_pending;
    assign bus.ovf     = r_ovf;
    assign bus.count   = r_count;
    assign bus.busy    = (|r_pending) | (r_state == PRESENT);

endmodule

// File: tb/tb_encoder_4x2_rr.sv
// Directed bench for encoder_4x2_rr: reset, latency, round-robin order, stall, overflow, mid-run reset.
module tb_encoder_4x2_rr;
    import encoder_4x2_rr_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    encoder_4x2_rr_if bus ();

    encoder_4x2_rr dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each tick lands 1 time unit after a rising edge: outputs are settled, inputs set here
    // are sampled at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic [7:0] exp_count);
        chk({tag, "_valid"},   32'(bus.valid),   32'd0);
        chk({tag, "_pending"}, 32'(bus.pending), 32'd0);
        chk({tag, "_count"},   32'(bus.count),   32'(exp_count));
        chk({tag, "_busy"},    32'(bus.busy),    32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        bus.en    = 1'b0;
        bus.req   = 4'b0000;
        bus.ready = 1'b0;

        // Reset held for two edges.
        tick();
        tick();
        rst = 1'b0;
        chk("rst_addr", 32'(bus.addr), 32'd0);
        chk("rst_ovf",  32'(bus.ovf),  32'd0);
        chk_idle("rst", 8'd0);

        // Single request: pending at N+1, presented at N+2, counted at N+3.
        bus.ready = 1'b1;
        bus.en    = 1'b1;
        bus.req   = 4'b0100;
        tick();
        bus.en  = 1'b0;
        bus.req = 4'b0000;
        chk("lat_pending_n1", 32'(bus.pending), 32'b0100);
        chk("lat_valid_n1",   32'(bus.valid),   32'd0);
        tick();
        chk("lat_valid_n2", 32'(bus.valid), 32'd1);
        chk("lat_addr_n2",  32'(bus.addr),  32'd2);
        chk("lat_count_n2", 32'(bus.count), 32'd0);
        tick();
        chk_idle("lat_n3", 8'd1);

        // Fresh reset so the pointer starts at 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("rst2", 8'd0);

        // All four requests, twice: order 0,1,2,3 both times, one per cycle.
        for (int pass = 0; pass < 2; pass++) begin
            bus.en  = 1'b1;
            bus.req = 4'b1111;
            tick();
            bus.en  = 1'b0;
            bus.req = 4'b0000;
            chk("rr_pending", 32'(bus.pending), 32'b1111);
            for (int i = 0; i < 4; i++) begin
                tick();
                chk("rr_valid", 32'(bus.valid), 32'd1);
                chk("rr_addr",  32'(bus.addr),  32'(i));
            end
            tick();
            chk_idle("rr_done", 8'(4 * (pass + 1)));
        end

        // Stall: addr 0 held while ready=0, bit 1 stays pending.
        bus.ready = 1'b0;
        bus.en    = 1'b1;
        bus.req   = 4'b0011;
        tick();
        bus.en  = 1'b0;
        bus.req = 4'b0000;
        chk("stall_pending_n1", 32'(bus.pending), 32'b0011);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid",   32'(bus.valid),   32'd1);
            chk("stall_addr",    32'(bus.addr),    32'd0);
            chk("stall_pending", 32'(bus.pending), 32'b0010);
            tick();
        end
        bus.ready = 1'b1;
        tick();
        chk("stall_next_addr",  32'(bus.addr),    32'd1);
        chk("stall_next_valid", 32'(bus.valid),   32'd1);
        chk("stall_next_count", 32'(bus.count),   32'd9);
        tick();
        chk_idle("stall_done", 8'd10);

        // Overflow: occupy the output with addr 0, then hit bit 1 twice while stalled.
        bus.ready = 1'b0;
        bus.en    = 1'b1;
        bus.req   = 4'b0001;
        tick();
        bus.en  = 1'b0;
        bus.req = 4'b0000;
        tick();
        chk("ovf_hold_addr", 32'(bus.addr), 32'd0);
        bus.en  = 1'b1;
        bus.req = 4'b0010;
        tick();
        chk("ovf_first",     32'(bus.ovf),     32'd0);
        chk("ovf_pending1",  32'(bus.pending), 32'b0010);
        tick();
        chk("ovf_pulse",     32'(bus.ovf),     32'd1);
        chk("ovf_merged",    32'(bus.pending), 32'b0010);
        bus.en  = 1'b0;
        bus.req = 4'b1111;
        tick();
        chk("ovf_cleared",   32'(bus.ovf),     32'd0);
        chk("en0_pending",   32'(bus.pending), 32'b0010);
        tick();
        chk("en0_pending2",  32'(bus.pending), 32'b0010);
        chk("en0_valid",     32'(bus.valid),   32'd1);
        bus.req   = 4'b0000;
        bus.ready = 1'b1;
        tick();
        chk("ovf_addr1",       32'(bus.addr),  32'd1);
        chk("ovf_addr1_valid", 32'(bus.valid), 32'd1);
        chk("ovf_addr1_count", 32'(bus.count), 32'd11);
        tick();
        chk_idle("ovf_done", 8'd12);
        chk("ovf_done_ovf", 32'(bus.ovf), 32'd0);

        // Reset while presenting discards everything without a handshake.
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        bus.ready = 1'b0;
        bus.en    = 1'b1;
        bus.req   = 4'b1010;
        tick();
        bus.en  = 1'b0;
        bus.req = 4'b0000;
        chk("mid_pending_n1", 32'(bus.pending), 32'b1010);
        tick();
        chk("mid_valid", 32'(bus.valid),   32'd1);
        chk("mid_addr",  32'(bus.addr),    32'd1);
        chk("mid_pend",  32'(bus.pending), 32'b1000);
        rst       = 1'b1;
        bus.ready = 1'b1;
        tick();
        rst       = 1'b0;
        bus.ready = 1'b0;
        chk("mid_rst_addr", 32'(bus.addr), 32'd0);
        chk("mid_rst_ovf",  32'(bus.ovf),  32'd0);
        chk_idle("mid_rst", 8'd0);
        tick();
        chk_idle("mid_after", 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
